// File: rtl/slt_pkg.sv
// rtl/slt_pkg.sv - shared state encoding, chunk-count helper and parameter checks for slt_unit
package slt_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int MIN_WIDTH     = 2;
    localparam int MIN_CHUNK     = 1;
    localparam int MIN_OUT_WIDTH = 1;

    function automatic int nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit params_ok(input int width, input int chunk, input int out_width);
        return (chunk >= MIN_CHUNK) && (width >= MIN_WIDTH) && (chunk <= width)
            && ((width % chunk) == 0) && (out_width >= MIN_OUT_WIDTH);
    endfunction

endpackage

// File: rtl/slt_chunk_cmp.sv
// rtl/slt_chunk_cmp.sv - combinational unsigned compare of one CHUNK-wide slice
module slt_chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq
);

    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/slt_unit.sv
// rtl/slt_unit.sv - MSB-first chunk-serial set-less-than with valid/ready on both sides
// optional cycles output enabled by SLT_UNIT_CYCLES_EN
module slt_unit
    import slt_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CHUNK     = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] res,
    output logic                 eq,
    output logic                 busy
`ifdef SLT_UNIT_CYCLES_EN
    ,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0] cycles
`endif
);

    localparam int NCH = nch(WIDTH, CHUNK);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NCH - 1);

    if (!params_ok(WIDTH, CHUNK, OUT_WIDTH)) begin : g_bad_params
        $error("slt_unit: WIDTH/CHUNK/OUT_WIDTH combination is invalid");
    end

    logic [1:0]                  state;
    logic [WIDTH-1:0]            ra;
    logic [WIDTH-1:0]            rb;
    logic [IW-1:0]               idx;
    logic                        lt_r;
    logic                        eq_r;
    logic [NCH-1:0][CHUNK-1:0]   ra_ch;
    logic [NCH-1:0][CHUNK-1:0]   rb_ch;
    logic                        ch_lt;
    logic                        ch_eq;

    assign ra_ch = ra;
    assign rb_ch = rb;

    slt_chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a  (ra_ch[idx]),
        .b  (rb_ch[idx]),
        .lt (ch_lt),
        .eq (ch_eq)
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign res       = OUT_WIDTH'(lt_r);
    assign eq        = eq_r;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            idx   <= IDX_TOP;
            lt_r  <= 1'b0;
            eq_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra    <= {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
                        rb    <= {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};
                        idx   <= IDX_TOP;
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (!ch_eq) begin
                        lt_r  <= ch_lt;
                        eq_r  <= 1'b0;
                        state <= DONE;
                    end else if (idx == '0) begin
                        lt_r  <= 1'b0;
                        eq_r  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SLT_UNIT_CYCLES_EN
    localparam int CW = $clog2(NCH + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            cycles <= '0;
        end else if (state == IDLE && in_valid) begin
            cnt <= '0;
        end else if (state == CMP) begin
            cnt <= cnt + 1'b1;
            if (!ch_eq || idx == '0) begin
                cycles <= cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_slt_unit.sv
// tb/tb_slt_unit.sv - self-checking bench for slt_unit (32/8 and 16/4 instances)
module tb_slt_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv32, ir32, s32, ov32, or32, eq32, busy32;
    logic [31:0] a32, b32, res32;
    logic        iv16, ir16, s16, ov16, or16, eq16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] res16;
`ifdef SLT_UNIT_CYCLES_EN
    logic [2:0]  cyc32, cyc16;
`endif

    slt_unit #(.WIDTH(32), .CHUNK(8), .OUT_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .is_signed(s32), .out_valid(ov32), .out_ready(or32), .res(res32), .eq(eq32),
        .busy(busy32)
`ifdef SLT_UNIT_CYCLES_EN
        , .cycles(cyc32)
`endif
    );

    slt_unit #(.WIDTH(16), .CHUNK(4), .OUT_WIDTH(32)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .is_signed(s16), .out_valid(ov16), .out_ready(or16), .res(res16), .eq(eq16),
        .busy(busy16)
`ifdef SLT_UNIT_CYCLES_EN
        , .cycles(cyc16)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: signed values via integer arithmetic, latency from highest differing bit.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  input int w, input int c, output bit lt, output bit eq,
                                  output int k);
        longint ea, eb;
        logic [31:0] x;
        int p;
        ea = longint'(a);
        eb = longint'(b);
        if (s && a[w-1]) ea = ea - (longint'(1) << w);
        if (s && b[w-1]) eb = eb - (longint'(1) << w);
        lt = (ea < eb);
        eq = (a == b);
        x = a ^ b;
        p = -1;
        for (int i = 0; i < w; i++) if (x[i]) p = i;
        k = (p < 0) ? (w / c) : ((w - 1 - p) / c + 1);
    endfunction

    function automatic logic f_ov(input bit w16);   return w16 ? ov16 : ov32;     endfunction
    function automatic logic f_ir(input bit w16);   return w16 ? ir16 : ir32;     endfunction
    function automatic logic f_busy(input bit w16); return w16 ? busy16 : busy32; endfunction
    function automatic logic f_eq(input bit w16);   return w16 ? eq16 : eq32;     endfunction
    function automatic logic [31:0] f_res(input bit w16); return w16 ? res16 : res32; endfunction

    task automatic op(input bit w16, input logic [31:0] a, input logic [31:0] b, input bit s,
                      input int hold, output int lat, output bit r, output bit e, output int cyc);
        logic [31:0] r_full;
        @(negedge clk);
        if (w16) begin a16 = a[15:0]; b16 = b[15:0]; s16 = s; iv16 = 1'b1; end
        else     begin a32 = a;       b32 = b;       s32 = s; iv32 = 1'b1; end
        chk("in_ready_before_accept", f_ir(w16), 1);
        @(negedge clk);
        // Operand changes while busy must not disturb the op in flight.
        if (w16) begin iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = ~s; end
        else     begin iv32 = 1'b0; a32 = $urandom;      b32 = $urandom;      s32 = ~s; end
        chk("busy_after_accept", f_busy(w16), 1);
        lat = 0;
        while (!f_ov(w16) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_within_budget", f_ov(w16), 1);
        r_full = f_res(w16);
        r = r_full[0];
        e = f_eq(w16);
        chk("res_upper_zero", r_full >> 1, 0);
        cyc = 0;
`ifdef SLT_UNIT_CYCLES_EN
        cyc = w16 ? int'(cyc16) : int'(cyc32);
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", f_ov(w16), 1);
            chk("hold_res", f_res(w16), r_full);
            chk("hold_eq", f_eq(w16), e);
            chk("hold_in_ready", f_ir(w16), 0);
        end
        if (w16) or16 = 1'b1; else or32 = 1'b1;
        @(negedge clk);
        if (w16) or16 = 1'b0; else or32 = 1'b0;
        chk("out_valid_drop", f_ov(w16), 0);
        chk("in_ready_after_handoff", f_ir(w16), 1);
    endtask

    typedef struct {
        bit          w16;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        bit          exp_lt;
        bit          exp_eq;
        int          exp_k;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat, cyc, k, w, c, sh;
        bit r, e, mlt, meq, w16;
        logic [31:0] ra, rb, msk;

        vecs.push_back('{0, 32'h12000000, 32'h13000000, 0, 1, 0, 1});
        vecs.push_back('{0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 4});
        vecs.push_back('{0, 32'hFFFFFFFF, 32'h00000001, 1, 1, 0, 1});
        vecs.push_back('{0, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 1});
        vecs.push_back('{0, 32'h00000005, 32'h00000007, 0, 1, 0, 4});
        vecs.push_back('{0, 32'h80000000, 32'h7FFFFFFF, 1, 1, 0, 1});
        vecs.push_back('{0, 32'h00001300, 32'h00001200, 0, 0, 0, 3});
        vecs.push_back('{1, 32'h00008000, 32'h00007FFF, 1, 1, 0, 1});
        vecs.push_back('{1, 32'h00007FFF, 32'h00008000, 1, 0, 0, 1});
        vecs.push_back('{1, 32'h00008000, 32'h00007FFF, 0, 0, 0, 1});
        vecs.push_back('{1, 32'h00001234, 32'h00001234, 1, 0, 1, 4});
        vecs.push_back('{1, 32'h00000010, 32'h00000020, 1, 1, 0, 3});

        rst_n = 1'b0;
        {iv32, s32, or32, iv16, s16, or16} = '0;
        a32 = '0; b32 = '0; a16 = '0; b16 = '0;
        #1;
        chk("reset_out_valid", ov32, 0);
        chk("reset_res", res32, 0);
        chk("reset_eq", eq32, 0);
        chk("reset_busy", busy32, 0);
`ifdef SLT_UNIT_CYCLES_EN
        chk("reset_cycles", cyc32, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset_32", ir32, 1);
        chk("in_ready_after_reset_16", ir16, 1);

        foreach (vecs[i]) begin
            op(vecs[i].w16, vecs[i].a, vecs[i].b, vecs[i].s, 0, lat, r, e, cyc);
            chk($sformatf("vec%0d_res", i), r, vecs[i].exp_lt);
            chk($sformatf("vec%0d_eq", i), e, vecs[i].exp_eq);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_k);
`ifdef SLT_UNIT_CYCLES_EN
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_k);
`endif
        end

        // Output backpressure with the difference in the lowest chunk.
        op(0, 32'h5, 32'h7, 0, 5, lat, r, e, cyc);
        chk("bp_res", r, 1);
        chk("bp_eq", e, 0);
        chk("bp_latency", lat, 4);

        // Reset during the second compare cycle.
        op(0, 32'h12000000, 32'h13000000, 0, 0, lat, r, e, cyc);
        @(negedge clk);
        a32 = '0; b32 = '0; s32 = 1'b0; iv32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0;
        @(negedge clk);
        chk("midop_busy_before_reset", busy32, 1);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_out_valid", ov32, 0);
        chk("midop_reset_res", res32, 0);
        chk("midop_reset_busy", busy32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op(0, 32'h1, 32'h0, 0, 0, lat, r, e, cyc);
        chk("post_reset_res", r, 0);
        chk("post_reset_eq", e, 0);
        chk("post_reset_latency", lat, 4);

        // Random ops, biased toward shared upper chunks to exercise every exit point.
        for (int n = 0; n < 60; n++) begin
            w16 = (n % 3 == 2);
            w = w16 ? 16 : 32;
            c = w16 ? 4 : 8;
            msk = w16 ? 32'h0000FFFF : 32'hFFFFFFFF;
            ra = $urandom & msk;
            case ($urandom_range(0, 3))
                0: rb = $urandom & msk;
                1: rb = ra;
                default: begin
                    sh = $urandom_range(0, w / c - 1) * c;
                    rb = (ra ^ ((32'($urandom_range(1, (1 << c) - 1)) << sh)
                                | (32'($urandom) & ((32'h1 << sh) - 1)))) & msk;
                end
            endcase
            e = $urandom_range(0, 1);
            model(ra, rb, e, w, c, mlt, meq, k);
            op(w16, ra, rb, e, $urandom_range(0, 2), lat, r, e, cyc);
            chk($sformatf("rand%0d_res a=%0h b=%0h", n, ra, rb), r, mlt);
            chk($sformatf("rand%0d_eq", n), e, meq);
            chk($sformatf("rand%0d_latency", n), lat, k);
`ifdef SLT_UNIT_CYCLES_EN
            chk($sformatf("rand%0d_cycles", n), cyc, k);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
